// File: rtl/t_ff_dff.sv
// t_ff_dff: vector of independent toggle flip-flops built on a D register.
// Optional T_FF_DFF_TOGGLE_CNT_EN adds a saturating count of toggle edges.
module t_ff_dff #(
  parameter int unsigned      WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic [WIDTH-1:0] t,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb
`ifdef T_FF_DFF_TOGGLE_CNT_EN
  ,
  output logic [15:0]      tog_cnt
`endif
);

  logic [WIDTH-1:0] d;

  // next state: reset value wins, else invert bits with t set
  always_comb begin
    d = q ^ t;
    if (rst) d = RESET_VALUE;
  end

  // plain D stage, no enable
  always_ff @(posedge clk) begin
    q <= d;
  end

  assign qb = ~q;

`ifdef T_FF_DFF_TOGGLE_CNT_EN
  logic any_tog;

  assign any_tog = |t;

  // count edges where some bit toggled, holding at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      tog_cnt <= '0;
    end else if (any_tog && (tog_cnt != 16'hFFFF)) begin
      tog_cnt <= tog_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_t_ff_dff.sv
// tb_t_ff_dff: table-driven scoreboard bench for t_ff_dff.
// Runs a 1-bit cell and a 4-bit cell with RESET_VALUE 4'b1010 side by side.
module tb_t_ff_dff;

  logic       clk = 1'b0;
  logic       rst;
  logic       t1;
  logic [3:0] t4;
  logic       q1, qb1;
  logic [3:0] q4, qb4;
`ifdef T_FF_DFF_TOGGLE_CNT_EN
  logic [15:0] cnt1, cnt4;
`endif

  always #5 clk = ~clk;

  t_ff_dff u1 (
    .t(t1), .clk(clk), .rst(rst), .q(q1), .qb(qb1)
`ifdef T_FF_DFF_TOGGLE_CNT_EN
    , .tog_cnt(cnt1)
`endif
  );

  t_ff_dff #(.WIDTH(4), .RESET_VALUE(4'b1010)) u4 (
    .t(t4), .clk(clk), .rst(rst), .q(q4), .qb(qb4)
`ifdef T_FF_DFF_TOGGLE_CNT_EN
    , .tog_cnt(cnt4)
`endif
  );

  typedef struct {
    logic       r;
    logic       a1;
    logic [3:0] a4;
    logic       e1;
    logic [3:0] e4;
  } vec_t;

  typedef struct {
    logic       e1;
    logic [3:0] e4;
    logic [15:0] c1;
    logic [15:0] c4;
    bit         cc;
    string      nm;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] m1 = '0;
  logic [15:0] m4 = '0;
  bit          have_prev = 0;
  logic        p1;
  logic [3:0]  p4;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic a1, input logic [3:0] a4,
                       input logic e1, input logic [3:0] e4,
                       input bit cc, input string nm);
    exp_t x;
    @(negedge clk);
    rst = r;
    t1  = a1;
    t4  = a4;
    if (r) begin
      m1 = '0;
      m4 = '0;
    end else begin
      if ((a1 === 1'b1) && m1 != 16'hFFFF) m1 = m1 + 16'd1;
      if ((|a4) === 1'b1 && m4 != 16'hFFFF) m4 = m4 + 16'd1;
    end
    x.e1 = e1; x.e4 = e4; x.c1 = m1; x.c4 = m4; x.cc = cc; x.nm = nm;
    sb.push_back(x);
    #1;
    if (have_prev) begin
      chk({nm, "/nocomb1"}, {63'd0, q1}, {63'd0, p1});
      chk({nm, "/nocomb4"}, {60'd0, q4}, {60'd0, p4});
    end
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({x.nm, "/q1"}, {63'd0, q1}, {63'd0, x.e1});
    chk({x.nm, "/qb1"}, {63'd0, qb1}, {63'd0, ~x.e1});
    chk({x.nm, "/q4"}, {60'd0, q4}, {60'd0, x.e4});
    chk({x.nm, "/qb4"}, {60'd0, qb4}, {60'd0, ~x.e4});
`ifdef T_FF_DFF_TOGGLE_CNT_EN
    if (x.cc) begin
      chk({x.nm, "/cnt1"}, {48'd0, cnt1}, {48'd0, x.c1});
      chk({x.nm, "/cnt4"}, {48'd0, cnt4}, {48'd0, x.c4});
    end
`endif
    p1 = x.e1;
    p4 = x.e4;
    have_prev = 1;
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b0;
    t1  = 1'b0;
    t4  = 4'b0;

    // reset with t set (reset wins), then hold
    tbl.push_back('{1, 1, 4'b1111, 0, 4'b1010});
    tbl.push_back('{0, 0, 4'b0000, 0, 4'b1010});
    tbl.push_back('{0, 0, 4'b0000, 0, 4'b1010});
    tbl.push_back('{0, 0, 4'b0000, 0, 4'b1010});
    // toggle sequence 0,1,0,1,1 ; vector 0110,1111,...
    tbl.push_back('{0, 0, 4'b0110, 0, 4'b1100});
    tbl.push_back('{0, 1, 4'b1111, 1, 4'b0011});
    tbl.push_back('{0, 0, 4'b0000, 1, 4'b0011});
    tbl.push_back('{0, 1, 4'b1000, 0, 4'b1011});
    tbl.push_back('{0, 1, 4'b0001, 1, 4'b1010});
    // reset mid-operation with toggles pending
    tbl.push_back('{1, 1, 4'b1111, 0, 4'b1010});
    tbl.push_back('{0, 0, 4'b0000, 0, 4'b1010});
    tbl.push_back('{0, 1, 4'b0101, 1, 4'b1111});
    // divide-by-2
    tbl.push_back('{1, 0, 4'b0000, 0, 4'b1010});
    for (int i = 0; i < 8; i++)
      tbl.push_back('{0, 1, 4'b1111, (i % 2 == 0),
                      (i % 2 == 0) ? 4'b0101 : 4'b1010});

    foreach (tbl[i])
      apply(tbl[i].r, tbl[i].a1, tbl[i].a4, tbl[i].e1, tbl[i].e4, 1,
            $sformatf("vec%0d", i));

    // counter: 5 toggle edges, 2 idle, then reset
    apply(1, 0, 4'b0000, 0, 4'b1010, 1, "cnt_rst");
    apply(0, 1, 4'b0001, 1, 4'b1011, 1, "cnt_a");
    apply(0, 1, 4'b0010, 0, 4'b1001, 1, "cnt_b");
    apply(0, 0, 4'b0000, 0, 4'b1001, 1, "cnt_idle0");
    apply(0, 1, 4'b0100, 1, 4'b1101, 1, "cnt_c");
    apply(0, 1, 4'b1000, 0, 4'b0101, 1, "cnt_d");
    apply(0, 0, 4'b0000, 0, 4'b0101, 1, "cnt_idle1");
    apply(0, 1, 4'b0001, 1, 4'b0100, 1, "cnt_e");
`ifdef T_FF_DFF_TOGGLE_CNT_EN
    chk("cnt_five1", {48'd0, cnt1}, 64'd5);
    chk("cnt_five4", {48'd0, cnt4}, 64'd5);
`endif
    apply(1, 1, 4'b1111, 0, 4'b1010, 1, "cnt_clear");

    // X on t corrupts only the affected bits; reset clears it
    apply(0, 1'bx, 4'b0x00, 1'bx, 4'b1x10, 0, "xprop");
    apply(1, 0, 4'b0000, 0, 4'b1010, 1, "xclear");

`ifdef T_FF_DFF_TOGGLE_CNT_EN
    // saturation: run far past 16'hFFFF toggle edges
    @(negedge clk);
    rst = 1'b0;
    t1  = 1'b1;
    t4  = 4'b1111;
    for (int i = 0; i < 65540; i++) @(negedge clk);
    t1 = 1'b0;
    t4 = 4'b0000;
    #1;
    chk("sat_cnt1", {48'd0, cnt1}, 64'h0000_0000_0000_FFFF);
    chk("sat_cnt4", {48'd0, cnt4}, 64'h0000_0000_0000_FFFF);
    chk("sat_q1", {63'd0, q1}, 64'd0);
    chk("sat_q4", {60'd0, q4}, {60'd0, 4'b1010});
    have_prev = 0;
    m1 = 16'hFFFF;
    m4 = 16'hFFFF;
    apply(1, 0, 4'b0000, 0, 4'b1010, 1, "sat_clear");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
